decode_immed_ctrl: RTL
======================

DECODE_IMMED_CTRL -- requirements
Module: decode_immed_ctrl

Interface
REQ-001 Parameter RESET_SEL, default 3'b000, immed_sel value driven while idle or in reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  fetch stage presents an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_instr  input  32  raw instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 flush  input  1  squash held instruction (branch redirect).
REQ-009 out_valid  output  1  decoded immediate/PC/flags valid for execute.
REQ-010 out_ready  input  1  execute consumes the output this cycle.
REQ-011 out_immed  output  32  sign/zero-extended immediate.
REQ-012 out_sel  output  3  immediate format code used.
REQ-013 out_pc  output  32  registered in_pc.
REQ-014 out_has_imm  output  1  instruction carries an immediate.
REQ-015 out_illegal  output  1  opcode not recognised.

Function
REQ-016 SHALL decode in_instr[6:0]: 0000011/0010011/1100111/1110011 -> sel 000 (I); 0100011 -> 001 (S); 1100011 -> 010 (B); 1101111 -> 011 (J); 0110111/0010111 -> 100 (U); 0110011 -> has_imm=0, sel RESET_SEL, immed 0; any other -> illegal=1, sel 111, immed 32'hDEADBEEF.
REQ-017 SHALL form immediates: I {21x b31,b30:20}; S {21x b31,b30:25,b11:7}; B {20x b31,b7,b30:25,b11:8,0}; J {12x b31,b19:12,b20,b30:21,0}; U {b31:12,12'b0}.
REQ-018 Handshake: accept when in_valid && in_ready; transfer when out_valid && out_ready.
REQ-019 in_ready = (state==RUN) && (!out_valid || out_ready); back-to-back acceptance with zero bubbles.
REQ-020 Latency exactly 1 cycle: instruction accepted at edge N appears at out_* after edge N.
REQ-021 Output register SHALL hold stable while out_valid && !out_ready.
REQ-022 FSM states RUN, TRAP; RUN->TRAP when an illegal instruction is accepted; TRAP holds out_valid=1, out_illegal=1, in_ready=0 regardless of out_ready; TRAP->RUN only on flush.
REQ-023 flush SHALL clear out_valid and force RUN next cycle; flush has priority over a same-cycle acceptance (instruction dropped) and over out_ready.
REQ-024 out_valid low: out_immed, out_pc hold last value; out_sel, out_has_imm, out_illegal don't-care but not X.

Reset
REQ-025 On rst: state RUN, out_valid 0, out_immed 0, out_pc 0, out_sel RESET_SEL, out_has_imm 0, out_illegal 0; in_ready 1 the cycle after rst deasserts.
REQ-026 rst asserted mid-transfer SHALL discard held instruction; rst dominates flush.

Configuration
REQ-027 Macro DECODE_PERF_EN: when defined, adds outputs perf_accept (32, count of accepted instructions) and perf_stall (32, cycles with out_valid && !out_ready), both wrap at 2^32, cleared by rst; when undefined, ports and counters absent and behaviour otherwise identical.

Structure
REQ-028 Shared package SHALL hold opcode constants, immediate-format enum (I,S,B,J,U,NONE=111), and FSM state enum.
REQ-029 Immediate formation SHALL be one instantiated sub-module, ImmedGen, driven by in_instr[31:7] and decoded select; decode and handshake remain in decode_immed_ctrl.

Verification
REQ-030 in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_sel=000, out_immed=0xFFFFFFFF.
REQ-031 Back-to-back 0x00112623 (sw), 0xFE000EE3 (beq -4), 0x0080006F (jal 8), 0x123452B7 (lui) -> out_immed 0x0000000C, 0xFFFFFFFC, 0x00000008, 0x12345000 on consecutive cycles, sel 001,010,011,100.
REQ-032 out_ready=0 for 3 cycles with valid output -> out_* stable, in_ready=0, perf_stall +3 (DECODE_PERF_EN).
REQ-033 in 0x0000007F -> out_illegal=1, immed 0xDEADBEEF, in_ready=0 persists with out_ready=1 until flush; after flush out_valid=0, in_ready=1.
REQ-034 flush and acceptance same cycle -> next cycle out_valid=0, instruction lost; rst mid-stall -> all outputs at reset values.

Source files
------------

// File: rtl/decode_immed_ctrl_pkg.sv
// Shared definitions for the decode/immediate stage: opcodes, immediate
// format codes, FSM states and the opcode decode helper.
package decode_immed_ctrl_pkg;

    // Base-ISA major opcodes (instr[6:0]).
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    // Marker value presented as the immediate of an unrecognised opcode.
    localparam logic [31:0] IllegalImmed = 32'hDEADBEEF;

    // Immediate format code; the encoding is visible on out_sel.
    typedef enum logic [2:0] {
        FmtI    = 3'b000,
        FmtS    = 3'b001,
        FmtB    = 3'b010,
        FmtJ    = 3'b011,
        FmtU    = 3'b100,
        FmtNone = 3'b111
    } imm_fmt_e;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StTrap = 1'b1
    } state_e;

    typedef struct packed {
        imm_fmt_e fmt;
        logic     has_imm;
        logic     illegal;
    } decode_t;

    // Classify a major opcode. R-type carries no immediate and is not
    // illegal; its fmt is FmtNone so the generator produces zero.
    function automatic decode_t decode_opcode(input logic [6:0] op);
        decode_t d;
        d.fmt     = FmtNone;
        d.has_imm = 1'b1;
        d.illegal = 1'b0;
        case (op)
            OpLoad, OpImm, OpJalr, OpSystem: d.fmt = FmtI;
            OpStore:                         d.fmt = FmtS;
            OpBranch:                        d.fmt = FmtB;
            OpJal:                           d.fmt = FmtJ;
            OpLui, OpAuipc:                  d.fmt = FmtU;
            OpReg:                           d.has_imm = 1'b0;
            default: begin
                d.has_imm = 1'b0;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_immed_ctrl_immed_gen.sv
// ImmedGen: assembles the sign-extended immediate for the selected format
// from instruction bits [31:7]. FmtNone yields zero.
module ImmedGen
    import decode_immed_ctrl_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] immed_o
);

    // Pure bit-shuffle per format; sign always comes from instr[31].
    always_comb begin
        immed_o = '0;
        case (fmt_i)
            FmtI: immed_o = {{21{instr_i[31]}}, instr_i[30:20]};
            FmtS: immed_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            FmtB: immed_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0};
            FmtJ: immed_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0};
            FmtU: immed_o = {instr_i[31:12], 12'b0};
            default: immed_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_immed_ctrl.sv
// decode_immed_ctrl: one-stage decode of the immediate field with a
// valid/ready handshake on both sides and a TRAP state that parks an
// illegal instruction on the output until a flush.
// Optional build macro: DECODE_PERF_EN adds perf_accept / perf_stall counters.
module decode_immed_ctrl
    import decode_immed_ctrl_pkg::*;
#(
    parameter logic [2:0] RESET_SEL = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_immed,
    output logic [2:0]  out_sel,
    output logic [31:0] out_pc,
    output logic        out_has_imm,
    output logic        out_illegal
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0] perf_accept,
    output logic [31:0] perf_stall
`endif
);

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] immed_q, immed_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] pc_q, pc_d;
    logic        has_imm_q, has_imm_d;
    logic        illegal_q, illegal_d;

    decode_t     dec;
    logic [31:0] gen_immed;
    logic [31:0] dec_immed;
    logic [2:0]  dec_sel;
    logic        accept;

    assign dec = decode_opcode(in_instr[6:0]);

    ImmedGen u_immed_gen (
        .instr_i (in_instr[31:7]),
        .fmt_i   (dec.fmt),
        .immed_o (gen_immed)
    );

    // Final immediate and select code as presented to execute.
    always_comb begin
        dec_immed = gen_immed;
        dec_sel   = dec.fmt;
        if (dec.illegal) begin
            dec_immed = IllegalImmed;
        end else if (!dec.has_imm) begin
            dec_immed = '0;
            dec_sel   = RESET_SEL;
        end
    end

    // Ready whenever running and the output slot is free or draining now.
    assign in_ready = (state_q == StRun) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state: flush beats everything, TRAP freezes, else load/drain.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        immed_d   = immed_q;
        sel_d     = sel_q;
        pc_d      = pc_q;
        has_imm_d = has_imm_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = StRun;
            valid_d = 1'b0;
        end else if (state_q == StTrap) begin
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d   = 1'b1;
            immed_d   = dec_immed;
            sel_d     = dec_sel;
            pc_d      = in_pc;
            has_imm_d = dec.has_imm;
            illegal_d = dec.illegal;
            state_d   = dec.illegal ? StTrap : StRun;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // FSM and output register file; synchronous reset dominates flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            valid_q   <= 1'b0;
            immed_q   <= '0;
            sel_q     <= RESET_SEL;
            pc_q      <= '0;
            has_imm_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            immed_q   <= immed_d;
            sel_q     <= sel_d;
            pc_q      <= pc_d;
            has_imm_q <= has_imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_immed   = immed_q;
    assign out_sel     = sel_q;
    assign out_pc      = pc_q;
    assign out_has_imm = has_imm_q;
    assign out_illegal = illegal_q;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_accept_q;
    logic [31:0] perf_stall_q;

    // Free-running wrap-around counters of handshakes and output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_accept_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (accept) begin
                perf_accept_q <= perf_accept_q + 32'd1;
            end
            if (valid_q && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_accept = perf_accept_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
